// File: rtl/ysyx_22040895_mdu_seq_pkg.sv
// Shared definitions for the multi-cycle MDU: widths, mduop codes, FSM states.
package ysyx_22040895_mdu_seq_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 7;

  typedef enum logic [3:0] {
    MduNone   = 4'd0,
    MduMul    = 4'd1,
    MduMulh   = 4'd2,
    MduMulhsu = 4'd3,
    MduMulhu  = 4'd4,
    MduDiv    = 4'd5,
    MduDivu   = 4'd6,
    MduRem    = 4'd7,
    MduRemu   = 4'd8
  } mduop_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMul  = 3'd1,
    StDiv  = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } mdu_state_e;

  // Sign-extend a 32-bit value to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22040895_mdu_iter.sv
// One datapath step of the MDU: shift-add multiply or restoring subtract-shift divide.
// Multiply: {acc, opnd} holds the running product, opnd[0] is the next multiplier bit.
// Divide:   acc is the partial remainder, opnd shifts dividend bits out and quotient bits in.
module ysyx_22040895_mdu_iter
  import ysyx_22040895_mdu_seq_pkg::*;
(
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_opnd,
  input  logic [XLEN-1:0] i_dsr,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_opnd
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  // Compute both step variants and select by operation.
  always_comb begin
    w_sum    = {1'b0, i_acc} + (i_opnd[0] ? {1'b0, i_dsr} : '0);
    w_rem_sh = {i_acc, i_opnd[XLEN-1]};
    w_ge     = (w_rem_sh >= {1'b0, i_dsr});
    // Only used when w_ge, so the true difference fits in XLEN bits.
    w_diff   = w_rem_sh[XLEN-1:0] - i_dsr;
    if (i_is_div) begin
      o_acc  = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
      o_opnd = {i_opnd[XLEN-2:0], w_ge};
    end else begin
      o_acc  = w_sum[XLEN:1];
      o_opnd = {w_sum[0], i_opnd[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ysyx_22040895_mdu_seq.sv
// Multi-cycle RV64M multiply/divide sequencer with valid/ready handshakes on both sides.
// Operands are reduced to magnitudes on accept; signs are re-applied in DONE.
module ysyx_22040895_mdu_seq
  import ysyx_22040895_mdu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      mduop_i,
  input  logic            wordop_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam logic [XLEN-1:0] AllOnes = '1;
  localparam logic [XLEN-1:0] MinD    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MinW    = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  mdu_state_e       r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [XLEN-1:0]  r_acc, w_acc_d;
  logic [XLEN-1:0]  r_opnd, w_opnd_d;
  logic [XLEN-1:0]  r_dsr, w_dsr_d;
  logic [3:0]       r_op, w_op_d;
  logic             r_word, w_word_d;
  logic             r_neg_q, w_neg_q_d;
  logic             r_neg_r, w_neg_r_d;
  logic [XLEN-1:0]  r_result, w_result_d;
  logic             r_out_valid, w_out_valid_d;

  // Incoming-op decode
  logic             w_op_ok, w_sgn1, w_sgn2, w_in_div, w_in_rem, w_in_sdiv;
  logic [XLEN-1:0]  w_a_ext, w_b_ext, w_a_abs, w_b_abs, w_min, w_fix_res;
  logic             w_s1, w_s2, w_dz, w_ovf;
  logic [CNT_W-1:0] w_n;

  // Iteration step and result assembly
  logic             w_is_div;
  logic [XLEN-1:0]  w_it_acc, w_it_opnd;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]  w_quot_s, w_rem_s, w_raw, w_final;

  // Decode the presented op and prepare magnitudes / special-case result.
  always_comb begin
    w_op_ok   = (mduop_i != 4'd0) && (mduop_i <= 4'd8);
    w_sgn1    = (mduop_i == MduMul) || (mduop_i == MduMulh) || (mduop_i == MduMulhsu) ||
                (mduop_i == MduDiv) || (mduop_i == MduRem);
    w_sgn2    = (mduop_i == MduMul) || (mduop_i == MduMulh) ||
                (mduop_i == MduDiv) || (mduop_i == MduRem);
    w_in_div  = (mduop_i >= 4'd5);
    w_in_rem  = (mduop_i == MduRem) || (mduop_i == MduRemu);
    w_in_sdiv = (mduop_i == MduDiv) || (mduop_i == MduRem);

    if (wordop_i) begin
      w_a_ext = w_sgn1 ? sext32(op1_i[31:0]) : {{(XLEN-32){1'b0}}, op1_i[31:0]};
      w_b_ext = w_sgn2 ? sext32(op2_i[31:0]) : {{(XLEN-32){1'b0}}, op2_i[31:0]};
      w_min   = MinW;
      w_n     = CNT_W'(XLEN/2);
    end else begin
      w_a_ext = op1_i;
      w_b_ext = op2_i;
      w_min   = MinD;
      w_n     = CNT_W'(XLEN);
    end

    w_s1    = w_sgn1 & w_a_ext[XLEN-1];
    w_s2    = w_sgn2 & w_b_ext[XLEN-1];
    w_a_abs = w_s1 ? -w_a_ext : w_a_ext;
    w_b_abs = w_s2 ? -w_b_ext : w_b_ext;

    w_dz  = (w_b_ext == '0);
    w_ovf = w_in_sdiv && (w_a_ext == w_min) && (w_b_ext == AllOnes);

    // Divide by zero returns the (width-adjusted, sign-extended) dividend as remainder.
    if (w_dz) begin
      if (w_in_rem) w_fix_res = wordop_i ? sext32(op1_i[31:0]) : op1_i;
      else          w_fix_res = AllOnes;
    end else begin
      w_fix_res = w_in_rem ? '0 : w_min;
    end
  end

  assign w_is_div = (r_state == StDiv);

  ysyx_22040895_mdu_iter u_iter (
    .i_is_div (w_is_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .i_dsr    (r_dsr),
    .o_acc    (w_it_acc),
    .o_opnd   (w_it_opnd)
  );

  // Sign-correct and select the final result from the iteration registers.
  always_comb begin
    // A word multiply runs half the steps, leaving the product 32 bits too high.
    w_prod   = r_word ? {{(XLEN/2){1'b0}}, r_acc, r_opnd[XLEN-1:XLEN/2]} : {r_acc, r_opnd};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_quot_s = r_neg_q ? -r_opnd : r_opnd;
    w_rem_s  = r_neg_r ? -r_acc : r_acc;
    unique case (r_op)
      MduMul:                       w_raw = w_prod_s[XLEN-1:0];
      MduMulh, MduMulhsu, MduMulhu: w_raw = w_prod_s[2*XLEN-1:XLEN];
      MduDiv, MduDivu:              w_raw = w_quot_s;
      MduRem, MduRemu:              w_raw = w_rem_s;
      default:                      w_raw = '0;
    endcase
    w_final = r_word ? sext32(w_raw[31:0]) : w_raw;
  end

  // FSM next-state and datapath register updates; flush overrides everything.
  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_acc_d       = r_acc;
    w_opnd_d      = r_opnd;
    w_dsr_d       = r_dsr;
    w_op_d        = r_op;
    w_word_d      = r_word;
    w_neg_q_d     = r_neg_q;
    w_neg_r_d     = r_neg_r;
    w_result_d    = r_result;
    w_out_valid_d = r_out_valid;

    if (flush_i) begin
      w_state_d     = StIdle;
      w_cnt_d       = '0;
      w_out_valid_d = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid_i && w_op_ok) begin
            w_op_d    = mduop_i;
            w_word_d  = wordop_i;
            w_neg_q_d = w_s1 ^ w_s2;
            w_neg_r_d = w_s1;
            if (w_in_div && (w_dz || w_ovf)) begin
              w_acc_d   = w_fix_res;
              w_opnd_d  = '0;
              w_dsr_d   = '0;
              w_cnt_d   = '0;
              w_state_d = StFix;
            end else if (w_in_div) begin
              w_acc_d   = '0;
              // Word divides start with the dividend in the upper half so that
              // half the steps consume all of its bits.
              w_opnd_d  = wordop_i ? {w_a_abs[XLEN/2-1:0], {(XLEN/2){1'b0}}} : w_a_abs;
              w_dsr_d   = w_b_abs;
              w_cnt_d   = w_n;
              w_state_d = StDiv;
            end else begin
              w_acc_d   = '0;
              w_opnd_d  = w_b_abs;
              w_dsr_d   = w_a_abs;
              w_cnt_d   = w_n;
              w_state_d = StMul;
            end
          end
        end
        StMul, StDiv: begin
          w_acc_d  = w_it_acc;
          w_opnd_d = w_it_opnd;
          w_cnt_d  = r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) w_state_d = StDone;
        end
        StFix: begin
          w_result_d    = r_acc;
          w_out_valid_d = 1'b1;
          w_state_d     = StDone;
        end
        StDone: begin
          if (!r_out_valid) begin
            w_result_d    = w_final;
            w_out_valid_d = 1'b1;
          end else if (out_ready_i) begin
            w_out_valid_d = 1'b0;
            w_state_d     = StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_dsr       <= '0;
      r_op        <= '0;
      r_word      <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_acc       <= w_acc_d;
      r_opnd      <= w_opnd_d;
      r_dsr       <= w_dsr_d;
      r_op        <= w_op_d;
      r_word      <= w_word_d;
      r_neg_q     <= w_neg_q_d;
      r_neg_r     <= w_neg_r_d;
      r_result    <= w_result_d;
      r_out_valid <= w_out_valid_d;
    end
  end

  assign in_ready_o  = (r_state == StIdle);
  assign out_valid_o = r_out_valid;
  assign result_o    = r_result;
  assign busy_o      = in_valid_i || (r_state != StIdle);

endmodule
